// File: rtl/imem_loader.sv
// Byte-stream program loader: assembles high/low byte pairs into 16-bit words, writes them to
// instruction memory from address 0, and holds the CPU until the image is complete.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require a trailing checksum word.
module imem_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              error,
  output logic [ADDR_W:0]   word_count,
  output logic [2:0]        dbg_state_o
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_LOAD_HI = 3'd0, S_LOAD_LO = 3'd1, S_WRITE = 3'd2, S_RUN = 3'd3,
    S_FAULT = 3'd4, S_CSUM_HI = 3'd5, S_CSUM_LO = 3'd6
  } state_e;
`else
  typedef enum logic [2:0] {
    S_LOAD_HI = 3'd0, S_LOAD_LO = 3'd1, S_WRITE = 3'd2, S_RUN = 3'd3, S_FAULT = 3'd4
  } state_e;
`endif

  state_e              state_q;
  logic                in_ready_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [15:0]         wdata_q;
  logic                hold_q;
  logic                done_q;
  logic                error_q;
  logic [ADDR_W:0]     count_q;
  logic                last_q;
  logic                accept;

  // Handshake: a byte transfers on a rising edge only when in_valid and in_ready are both 1;
  // in_ready is registered, so the source sees it a full cycle before the edge it applies to.
  assign accept = in_valid & in_ready_q;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [15:0] sum_q;
  logic [7:0]  csum_hi_q;
  logic [15:0] csum_total;
  assign csum_total = sum_q + {csum_hi_q, in_byte};
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_LOAD_HI;
      in_ready_q <= 1'b1;
      mem_we_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      hold_q     <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      count_q    <= '0;
      last_q     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q      <= '0;
      csum_hi_q  <= '0;
`endif
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        S_LOAD_HI: begin
          if (accept) begin
            if (in_last) begin
              // An odd byte count leaves a half word; it is dropped, never written.
              error_q    <= 1'b1;
              in_ready_q <= 1'b0;
              state_q    <= S_FAULT;
            end else begin
              wdata_q[15:8] <= in_byte;
              state_q       <= S_LOAD_LO;
            end
          end
        end
        S_LOAD_LO: begin
          if (accept) begin
            wdata_q[7:0] <= in_byte;
            last_q       <= in_last;
            in_ready_q   <= 1'b0;
            mem_we_q     <= 1'b1;
            state_q      <= S_WRITE;
          end
        end
        S_WRITE: begin
          count_q <= count_q + 1'b1;
          if (addr_q != '1) addr_q <= addr_q + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_q <= sum_q + wdata_q;
`endif
          if (last_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            in_ready_q <= 1'b1;
            state_q    <= S_CSUM_HI;
`else
            hold_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_RUN;
`endif
          end else if (addr_q == '1) begin
            error_q <= 1'b1;
            state_q <= S_FAULT;
          end else begin
            in_ready_q <= 1'b1;
            state_q    <= S_LOAD_HI;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM_HI: begin
          if (accept) begin
            csum_hi_q <= in_byte;
            state_q   <= S_CSUM_LO;
          end
        end
        S_CSUM_LO: begin
          if (accept) begin
            in_ready_q <= 1'b0;
            if (csum_total == 16'h0000) begin
              hold_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_RUN;
            end else begin
              error_q <= 1'b1;
              state_q <= S_FAULT;
            end
          end
        end
`endif
        S_RUN, S_FAULT: begin
          in_ready_q <= 1'b0;
        end
        default: begin
          in_ready_q <= 1'b0;
          hold_q     <= 1'b1;
          done_q     <= 1'b0;
          error_q    <= 1'b1;
          state_q    <= S_FAULT;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign cpu_hold    = hold_q;
  assign load_done   = done_q;
  assign error       = error_q;
  assign word_count  = count_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a word-level model queues expected writes, a negedge
// monitor checks every cycle, and each scenario ends with hand-computed literal checks.
module tb_imem_loader;

  localparam int ADDR_W = 10;
  localparam int ENT_W  = 1 + ADDR_W + 16;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic              in_valid = 1'b0;
  logic [7:0]        in_byte  = 8'h00;
  logic              in_last  = 1'b0;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              cpu_hold;
  logic              load_done;
  logic              error;
  logic [ADDR_W:0]   word_count;
  logic [2:0]        dbg_state;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_byte(in_byte), .in_last(in_last),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .load_done(load_done), .error(error), .word_count(word_count),
    .dbg_state_o(dbg_state)
  );

  // scoreboard / model state
  logic [ENT_W-1:0] exp_q[$];
  logic [15:0]      mem_model [0:(1<<ADDR_W)-1];
  int               total = 0;
  int               bad = 0;
  int               writes_seen = 0;
  int               model_addr = 0;
  logic [15:0]      sum_model = 16'h0;
  bit               pending_last = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // per-cycle monitor
  always @(negedge clock) begin
    logic [ENT_W-1:0] e;
    if (!reset) begin
      check("word_count_tracks_writes", 32'(word_count), 32'(writes_seen));
      check("hold_is_not_done", 32'(cpu_hold), 32'(!load_done));
      if (pending_last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        check("after_last_hold", 32'(cpu_hold), 32'd1);
        check("after_last_ready_for_csum", 32'(in_ready), 32'd1);
`else
        check("after_last_done", 32'(load_done), 32'd1);
        check("after_last_hold", 32'(cpu_hold), 32'd0);
`endif
      end
      pending_last = 1'b0;
      if (mem_we) begin
        check("ready_low_in_write", 32'(in_ready), 32'd0);
        if (exp_q.size() == 0) begin
          check("we_with_nothing_expected", 32'(mem_we), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("write_addr", 32'(mem_addr), 32'(e[ENT_W-2:16]));
          check("write_data", 32'(mem_wdata), 32'(e[15:0]));
          pending_last = e[ENT_W-1];
        end
        mem_model[mem_addr] = mem_wdata;
        writes_seen++;
      end
    end
  end

  // driver tasks (called from negedge context)
  task automatic do_reset();
    #2 reset = 1'b1;
    in_valid = 1'b0;
    #1;
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_word_count", 32'(word_count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    writes_seen  = 0;
    model_addr   = 0;
    sum_model    = 16'h0;
    pending_last = 1'b0;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last, input int gap);
    int n;
    in_valid = 1'b1;
    in_byte  = b;
    in_last  = last;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("byte_accept_timeout", 32'(in_ready), 32'd1);
    @(negedge clock);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (gap) @(negedge clock);
  endtask

  task automatic send_word(input logic [15:0] w, input logic last, input int gap);
    send_byte(w[15:8], 1'b0, gap);
    exp_q.push_back({last, ADDR_W'(model_addr), w});
    model_addr++;
    sum_model = sum_model + w;
    send_byte(w[7:0], last, gap);
  endtask

  task automatic send_csum(input logic [15:0] c);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(c[15:8], 1'b1, 0);
    send_byte(c[7:0], 1'b0, 0);
`else
    c = c;
`endif
  endtask

  task automatic wait_end();
    int n = 0;
    while (!load_done && !error && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("end_reached", 32'(load_done | error), 32'd1);
    repeat (2) @(negedge clock);
  endtask

  task automatic run_ignore(input int cycles);
    in_valid = 1'b1;
    in_byte  = 8'hA5;
    repeat (cycles) begin
      @(negedge clock);
      check("ignore_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
  endtask

  logic [15:0] reload_w [0:4];

  initial begin
    reload_w[0] = 16'h1234; reload_w[1] = 16'hBEEF; reload_w[2] = 16'h0001;
    reload_w[3] = 16'h8000; reload_w[4] = 16'hFFFF;
    @(negedge clock);
    do_reset();

    // basic two-word image
    send_word(16'h710F, 1'b0, 0);
    send_word(16'h7207, 1'b1, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_csum(16'h1CEA);
`endif
    wait_end();
    check("basic_count", 32'(word_count), 32'd2);
    check("basic_error", 32'(error), 32'd0);
    check("basic_done", 32'(load_done), 32'd1);
    check("basic_hold", 32'(cpu_hold), 32'd0);
    check("basic_mem0", 32'(mem_model[0]), 32'h710F);
    check("basic_mem1", 32'(mem_model[1]), 32'h7207);
    check("basic_queue_drained", 32'(exp_q.size()), 32'd0);
    run_ignore(10);
    check("ignore_count", 32'(word_count), 32'd2);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // bad checksum
    do_reset();
    send_word(16'h710F, 1'b0, 0);
    send_word(16'h7207, 1'b1, 0);
    send_csum(16'h1CEB);
    wait_end();
    check("badsum_error", 32'(error), 32'd1);
    check("badsum_hold", 32'(cpu_hold), 32'd1);
    check("badsum_count", 32'(word_count), 32'd2);
`endif

    // odd byte count
    do_reset();
    send_word(16'h710F, 1'b0, 0);
    send_byte(8'h72, 1'b1, 0);
    wait_end();
    check("odd_error", 32'(error), 32'd1);
    check("odd_count", 32'(word_count), 32'd1);
    check("odd_hold", 32'(cpu_hold), 32'd1);
    check("odd_done", 32'(load_done), 32'd0);

    // reset mid-load then full reload
    do_reset();
    for (int i = 0; i < 3; i++) send_word(16'hC000 + 16'(i), 1'b0, 0);
    begin
      int n = 0;
      while (writes_seen < 3 && n < 20) begin
        @(negedge clock);
        n++;
      end
      check("midload_three_writes", 32'(writes_seen), 32'd3);
    end
    do_reset();
    for (int i = 0; i < 5; i++) send_word(reload_w[i], (i == 4), 1);
    send_csum(16'(-sum_model));
    wait_end();
    check("reload_count", 32'(word_count), 32'd5);
    check("reload_done", 32'(load_done), 32'd1);
    check("reload_mem0", 32'(mem_model[0]), 32'h1234);
    check("reload_mem4", 32'(mem_model[4]), 32'hFFFF);

    // overflow: 1024 words with no last, in_valid toggled
    do_reset();
    for (int i = 0; i < (1 << ADDR_W); i++) send_word(16'(i * 7 + 3), 1'b0, 1);
    wait_end();
    check("ovf_error", 32'(error), 32'd1);
    check("ovf_count", 32'(word_count), 32'd1024);
    check("ovf_writes", 32'(writes_seen), 32'd1024);
    check("ovf_hold", 32'(cpu_hold), 32'd1);
    check("ovf_mem1023", 32'(mem_model[1023]), 32'h1BFC);
    run_ignore(5);
    check("ovf_no_more_writes", 32'(writes_seen), 32'd1024);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
